// File: rtl/render_arith_pkg.sv
// Shared arithmetic helpers for the render pipeline blocks: pipeline depth
// limits and signed saturation bounds for a given result width.
package render_arith_pkg;

  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 4;

  // Wide enough to compare any scaled product against any result width.
  localparam int SAT_CMP_W = 64;
  typedef logic signed [SAT_CMP_W-1:0] sat_cmp_t;

  function automatic sat_cmp_t sat_max(input int width);
    return (sat_cmp_t'(1) <<< (width - 1)) - sat_cmp_t'(1);
  endfunction

  function automatic sat_cmp_t sat_min(input int width);
    return -(sat_cmp_t'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/main_process_smul_round.sv
// Combinational round-half-up, arithmetic right shift and narrowing of a
// signed product. Clamps out-of-range results when SMUL_PIPE_SAT_EN is defined.
module main_process_smul_round
  import render_arith_pkg::*;
#(
  parameter int PROD_WIDTH = 32,
  parameter int DOUT_WIDTH = 28,
  parameter int SHIFT      = 0
) (
  input  logic signed [PROD_WIDTH-1:0] prod,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         ovf
);

  // One guard bit so the rounding constant can never overflow the product.
  localparam int SW = PROD_WIDTH + 1;

  logic signed [SW-1:0] prod_ext;
  logic signed [SW-1:0] scaled;

  assign prod_ext = SW'(prod);

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [SW-1:0] HALF = SW'(1) <<< (SHIFT - 1);
      assign scaled = (prod_ext + HALF) >>> SHIFT;
    end else begin : g_plain
      assign scaled = prod_ext;
    end
  endgenerate

`ifdef SMUL_PIPE_SAT_EN
  localparam sat_cmp_t MAX_V = sat_max(DOUT_WIDTH);
  localparam sat_cmp_t MIN_V = sat_min(DOUT_WIDTH);

  sat_cmp_t scaled_w;
  assign scaled_w = sat_cmp_t'(scaled);

  always_comb begin
    dout = DOUT_WIDTH'(scaled);
    ovf  = 1'b0;
    if (scaled_w > MAX_V) begin
      dout = MAX_V[DOUT_WIDTH-1:0];
      ovf  = 1'b1;
    end else if (scaled_w < MIN_V) begin
      dout = MIN_V[DOUT_WIDTH-1:0];
      ovf  = 1'b1;
    end
  end
`else
  assign dout = DOUT_WIDTH'(scaled);
  assign ovf  = 1'b0;
`endif

endmodule

// File: rtl/main_process_smul_pipe.sv
// Pipelined signed multiplier with clock enable, valid tracking and fixed-point
// scaling. Define SMUL_PIPE_SAT_EN to saturate instead of wrap on overflow.
module main_process_smul_pipe
  import render_arith_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 28,
  parameter int SHIFT      = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         out_valid,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         ovf
);

  localparam int PW    = din0_WIDTH + din1_WIDTH;
  localparam int DEPTH = (NUM_STAGE < NUM_STAGE_MIN) ? NUM_STAGE_MIN :
                         (NUM_STAGE > NUM_STAGE_MAX) ? NUM_STAGE_MAX : NUM_STAGE;

  logic signed [PW-1:0]         mul_prod;
  logic signed [PW-1:0]         final_prod;
  logic                         final_vld;
  logic signed [dout_WIDTH-1:0] rnd_dout;
  logic                         rnd_ovf;

  logic                         out_valid_q, out_valid_d;
  logic signed [dout_WIDTH-1:0] dout_q, dout_d;
  logic                         ovf_q, ovf_d;

  assign mul_prod = din0 * din1;

  generate
    // ID is a pure instance tag; this block is intentionally empty.
    if (ID < 0) begin : g_id_tag
    end

    if (DEPTH == 1) begin : g_single
      assign final_prod = mul_prod;
      assign final_vld  = in_valid;
    end else begin : g_multi
      localparam int MID = DEPTH - 1;

      logic signed [PW-1:0] prod_q [MID];
      logic signed [PW-1:0] prod_d [MID];
      logic [MID-1:0]       vld_q, vld_d;

      // Product registers carry don't-care data when their valid bit is low.
      always_comb begin
        prod_d = prod_q;
        vld_d  = vld_q;
        if (ce) begin
          prod_d[0] = mul_prod;
          vld_d[0]  = in_valid;
          for (int i = 1; i < MID; i++) begin
            prod_d[i] = prod_q[i-1];
            vld_d[i]  = vld_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q  <= '0;
          prod_q <= '{default: '0};
        end else begin
          vld_q  <= vld_d;
          prod_q <= prod_d;
        end
      end

      assign final_prod = prod_q[MID-1];
      assign final_vld  = vld_q[MID-1];
    end
  endgenerate

  main_process_smul_round #(
    .PROD_WIDTH (PW),
    .DOUT_WIDTH (dout_WIDTH),
    .SHIFT      (SHIFT)
  ) u_round (
    .prod (final_prod),
    .dout (rnd_dout),
    .ovf  (rnd_ovf)
  );

  // Result registers load only for valid samples so dout holds across gaps.
  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    ovf_d       = ovf_q;
    if (ce) begin
      out_valid_d = final_vld;
      if (final_vld) begin
        dout_d = rnd_dout;
        ovf_d  = rnd_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/main_process_smul_pipe.md
MAIN_PROCESS_SMUL_PIPE -- requirements
Module: main_process_smul_pipe

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-002 Parameter ID, default 1, SHALL be an instance tag with no functional effect.
REQ-003 Parameter NUM_STAGE, default 2, SHALL set the pipeline depth, legal range 1..4.
REQ-004 Parameter din0_WIDTH, default 16, SHALL set the signed operand A width.
REQ-005 Parameter din1_WIDTH, default 16, SHALL set the signed operand B width.
REQ-006 Parameter dout_WIDTH, default 28, SHALL set the signed result width.
REQ-007 Parameter SHIFT, default 0, SHALL set the fixed-point right shift applied to the product, legal range 0..din0_WIDTH+din1_WIDTH-1.
REQ-008 Port clk, input, 1 bit, SHALL be the rising-edge clock.
REQ-009 Port reset, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-010 Port ce, input, 1 bit, SHALL be the clock enable; when low, all pipeline registers hold.
REQ-011 Port in_valid, input, 1 bit, SHALL mark din0/din1 as valid this cycle.
REQ-012 Port din0, input, din0_WIDTH bits, SHALL carry signed operand A.
REQ-013 Port din1, input, din1_WIDTH bits, SHALL carry signed operand B.
REQ-014 Port out_valid, output, 1 bit, SHALL mark dout/ovf as valid.
REQ-015 Port dout, output, dout_WIDTH bits, SHALL carry the signed scaled product.
REQ-016 Port ovf, output, 1 bit, SHALL flag that the result was clamped for this sample.

Function
REQ-017 The full product SHALL be computed at P = din0_WIDTH+din1_WIDTH bits, signed, with no loss.
REQ-018 When SHIFT>0, the block SHALL add 2^(SHIFT-1) to P, then shift right arithmetically by SHIFT (round half toward +inf).
REQ-019 When SHIFT=0, the block SHALL apply no rounding.
REQ-020 Latency SHALL be exactly NUM_STAGE ce-high cycles from the in_valid sample to the matching out_valid.
REQ-021 The pipeline SHALL accept one sample per ce-high cycle with no bubbles.
REQ-022 While ce is low, out_valid, dout and ovf SHALL hold their values and input samples SHALL be ignored.
REQ-023 The valid bit SHALL travel alongside the data; data in stages with valid=0 SHALL be don't-care internally, but dout SHALL update only when out_valid rises or stays high.
REQ-024 The multiply SHALL occupy stage 1; round/shift and narrowing SHALL occupy the final stage; when NUM_STAGE=1, both SHALL be in the single stage.
REQ-025 When the scaled value fits in dout_WIDTH, dout SHALL equal it exactly and ovf SHALL be 0.

Reset
REQ-026 While reset is high, all valid bits SHALL clear, dout SHALL be 0 and ovf SHALL be 0, regardless of ce.
REQ-027 A reset asserted mid-operation SHALL discard all in-flight samples; no out_valid SHALL appear for samples accepted before reset.
REQ-028 The first sample after reset deasserts SHALL emerge after NUM_STAGE ce-high cycles.

Configuration
REQ-029 With macro SMUL_PIPE_SAT_EN defined, an out-of-range scaled value SHALL clamp to +(2^(dout_WIDTH-1))-1 or -2^(dout_WIDTH-1), with ovf=1 for that sample.
REQ-030 Without SMUL_PIPE_SAT_EN, dout SHALL be the low dout_WIDTH bits of the scaled value (wrap) and ovf SHALL be tied to 0.

Structure
REQ-031 Shared package render_arith_pkg SHALL hold the NUM_STAGE limits and the saturation min/max helper constants.
REQ-032 One sub-module, main_process_smul_round (combinational round, shift, saturate or wrap), SHALL be instantiated in the final stage.

Verification
REQ-033 Defaults, SAT_EN on: din0=-32768, din1=-32768 -> after 2 cycles dout=134217727, ovf=1; SAT_EN off -> dout=0, ovf=0.
REQ-034 SHIFT=4: 3*7 -> dout=1; -3*7 -> dout=-1; 1*8 -> dout=1 (round half up).
REQ-035 Stream of 5 back-to-back samples 1*1..5*5 -> out_valid high for 5 consecutive cycles carrying 1, 4, 9, 16, 25.
REQ-036 Drive 2*3, drop ce for 3 cycles after 1 cycle -> dout=6 appears exactly 3 cycles late; outputs frozen during the stall.
REQ-037 Reset pulse while 2 samples are in flight -> no out_valid follows; dout=0, ovf=0; next sample 4*5 -> dout=20.
REQ-038 NUM_STAGE=1 and NUM_STAGE=4, with 100 random operands each -> results match the reference model at the exact latency.
